// File: rtl/ram16_8_bist.sv
// March C- built-in self-test initiator for the 16x8 synchronous RAM.
// Optional macro BIST_ABORT_ON_FAIL_EN stops the test at the first mismatch.
module ram16_8_bist #(
   parameter logic [7:0] PATTERN = 8'h55
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] mem_dataout,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_datain,
   output logic       mem_read,
   output logic       mem_write,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [3:0] fail_addr,
   output logic [7:0] fail_exp,
   output logic [7:0] fail_act,
   output logic [7:0] err_cnt
);

   typedef enum logic [2:0] {IDLE, W0, RD, WRC, R5, C5, DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic [2:0] elem_q, elem_d;
   logic [3:0] mem_addr_q, mem_addr_d;
   logic [7:0] mem_datain_q, mem_datain_d;
   logic       mem_read_q, mem_read_d;
   logic       mem_write_q, mem_write_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fail_q, fail_d;
   logic [3:0] fail_addr_q, fail_addr_d;
   logic [7:0] fail_exp_q, fail_exp_d;
   logic [7:0] fail_act_q, fail_act_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   logic [7:0] exp_val;
   logic       mismatch;
   logic       dir_down;
   logic       elem_last;

   // Odd elements (E1, E3) read the "0" background; even ones read the "1" value.
   always_comb begin
      exp_val   = (state_q == C5 || elem_q[0]) ? PATTERN : ~PATTERN;
      mismatch  = (state_q == WRC || state_q == C5) && (mem_dataout != exp_val);
      dir_down  = (elem_q == 3'd3) || (elem_q == 3'd4);
      elem_last = dir_down ? (addr_q == 4'd0) : (addr_q == 4'd15);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      elem_d      = elem_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_act_d  = fail_act_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = W0;
               addr_d      = 4'd0;
               elem_d      = 3'd0;
               fail_d      = 1'b0;
               fail_addr_d = 4'd0;
               fail_exp_d  = 8'd0;
               fail_act_d  = 8'd0;
               err_cnt_d   = 8'd0;
            end
         end
         W0: begin
            if (addr_q == 4'd15) begin
               state_d = RD;
               elem_d  = 3'd1;
               addr_d  = 4'd0;
            end else begin
               addr_d = addr_q + 4'd1;
            end
         end
         RD: state_d = WRC;
         WRC: begin
            state_d = RD;
            if (elem_last) begin
               if (elem_q == 3'd4) begin
                  state_d = R5;
                  addr_d  = 4'd0;
               end else begin
                  elem_d = elem_q + 3'd1;
                  // E3 and E4 descend, so they start from the top address.
                  addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? 4'd15 : 4'd0;
               end
            end else begin
               addr_d = dir_down ? addr_q - 4'd1 : addr_q + 4'd1;
            end
         end
         R5: state_d = C5;
         C5: begin
            if (addr_q == 4'd15) begin
               state_d = DONE;
            end else begin
               state_d = R5;
               addr_d  = addr_q + 4'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (mismatch) begin
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
         if (!fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = addr_q;
            fail_exp_d  = exp_val;
            fail_act_d  = mem_dataout;
         end
`ifdef BIST_ABORT_ON_FAIL_EN
         state_d = DONE;
`else
`endif
      end
   end

   // RAM pins are registered, so they are derived from the state being entered.
   always_comb begin
      busy_d       = (state_d != IDLE) && (state_d != DONE);
      done_d       = (state_d == DONE);
      mem_read_d   = (state_d == RD) || (state_d == R5);
      mem_write_d  = (state_d == W0) || (state_d == WRC);
      mem_addr_d   = busy_d ? addr_d : 4'd0;
      mem_datain_d = 8'd0;
      if (state_d == W0) begin
         mem_datain_d = PATTERN;
      end else if (state_d == WRC) begin
         mem_datain_d = elem_d[0] ? ~PATTERN : PATTERN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= 4'd0;
         elem_q       <= 3'd0;
         mem_addr_q   <= 4'd0;
         mem_datain_q <= 8'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_addr_q  <= 4'd0;
         fail_exp_q   <= 8'd0;
         fail_act_q   <= 8'd0;
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         elem_q       <= elem_d;
         mem_addr_q   <= mem_addr_d;
         mem_datain_q <= mem_datain_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         fail_addr_q  <= fail_addr_d;
         fail_exp_q   <= fail_exp_d;
         fail_act_q   <= fail_act_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_datain = mem_datain_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fail       = fail_q;
   assign fail_addr  = fail_addr_q;
   assign fail_exp   = fail_exp_q;
   assign fail_act   = fail_act_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ram16_8_bist.sv
// Directed testbench for ram16_8_bist with a 16x8 RAM model and optional stuck-at fault.
module tb_ram16_8_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] mem_dataout = 8'd0;
   logic [3:0] mem_addr;
   logic [7:0] mem_datain;
   logic       mem_read;
   logic       mem_write;
   logic       busy;
   logic       done;
   logic       fail;
   logic [3:0] fail_addr;
   logic [7:0] fail_exp;
   logic [7:0] fail_act;
   logic [7:0] err_cnt;

   logic [7:0] mem [0:15];
   logic       fault_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic       busy_h [0:199];
   logic       done_h [0:199];
   logic       rd_h   [0:199];
   logic       wr_h   [0:199];
   logic       fail_h [0:199];
   logic       zero_h [0:199];
   logic [3:0] addr_h [0:199];

   int busy_cnt, done_cyc, rd_cnt, wr_cnt, both_cnt;

   ram16_8_bist #(.PATTERN(8'h55)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_dataout(mem_dataout),
      .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_read(mem_read),
      .mem_write(mem_write), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // RAM model; the fault forces bit 0 of address 5 to 0 on every write.
   always @(posedge clk) begin
      if (mem_write)
         mem[mem_addr] <= (fault_en && mem_addr == 4'd5) ? (mem_datain & 8'hFE) : mem_datain;
      if (mem_read)
         mem_dataout <= mem[mem_addr];
   end

   task automatic run_session(input int ncyc, input bit hold, input int rst_cycle);
      int lim;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         busy_h[k] = busy;
         done_h[k] = done;
         rd_h[k]   = mem_read;
         wr_h[k]   = mem_write;
         fail_h[k] = fail;
         addr_h[k] = mem_addr;
         zero_h[k] = ({mem_addr, mem_datain, mem_read, mem_write, busy, done, fail,
                       fail_addr, fail_exp, fail_act, err_cnt} == '0);
         rst = (k == rst_cycle);
      end
      start = 1'b0;
      rst = 1'b0;
      lim = (ncyc < 178) ? ncyc : 178;
      busy_cnt = 0; done_cyc = -1; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      for (int k = 1; k <= lim; k++) begin
         if (busy_h[k]) busy_cnt++;
         if (rd_h[k]) rd_cnt++;
         if (wr_h[k]) wr_cnt++;
         if (rd_h[k] && wr_h[k]) both_cnt++;
         if (done_h[k] && done_cyc < 0) done_cyc = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
      n_cmp++; if ({mem_addr, mem_datain} !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_bus: got %h want 000", {mem_addr, mem_datain}); end
      n_cmp++; if ({fail, fail_addr, fail_exp, fail_act, err_cnt} !== 29'd0) begin n_bad++; $display("[TB] FAIL reset_status: got %h want 0", {fail, fail_addr, fail_exp, fail_act, err_cnt}); end
   endtask

   task automatic test_fault_free();
      int e3_bad;
      fault_en = 1'b0;
      run_session(185, 1'b0, -1);
      n_cmp++; if (busy_h[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL ff_busy_c1: got %b want 1", busy_h[1]); end
      n_cmp++; if (busy_cnt !== 176) begin n_bad++; $display("[TB] FAIL ff_busy_cnt: got %0d want 176", busy_cnt); end
      n_cmp++; if (done_cyc !== 177) begin n_bad++; $display("[TB] FAIL ff_done_cyc: got %0d want 177", done_cyc); end
      n_cmp++; if ({busy_h[178], done_h[178]} !== 2'b00) begin n_bad++; $display("[TB] FAIL ff_idle_c178: got %b want 00", {busy_h[178], done_h[178]}); end
      n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("[TB] FAIL ff_fail: got %b want 0", fail); end
      n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL ff_err_cnt: got %0d want 0", err_cnt); end
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("[TB] FAIL ff_both_strobes: got %0d want 0", both_cnt); end
      n_cmp++; if (wr_cnt !== 80) begin n_bad++; $display("[TB] FAIL ff_write_cnt: got %0d want 80", wr_cnt); end
      n_cmp++; if (rd_cnt !== 80) begin n_bad++; $display("[TB] FAIL ff_read_cnt: got %0d want 80", rd_cnt); end
      e3_bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (rd_h[81 + 2*i] !== 1'b1 || addr_h[81 + 2*i] !== 4'(15 - i)) e3_bad++;
      end
      n_cmp++; if (e3_bad !== 0) begin n_bad++; $display("[TB] FAIL ff_e3_read_order: got %0d bad reads want 0", e3_bad); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (mem[i] !== 8'h55) begin n_bad++; $display("[TB] FAIL ff_mem_final[%0d]: got %h want 55", i, mem[i]); end
      end
   endtask

   task automatic test_stuck_fault();
      int exp_err, exp_done;
`ifdef BIST_ABORT_ON_FAIL_EN
      exp_err = 1; exp_done = 29;
`else
      exp_err = 3; exp_done = 177;
`endif
      fault_en = 1'b1;
      run_session(185, 1'b0, -1);
      n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("[TB] FAIL sf_fail: got %b want 1", fail); end
      n_cmp++; if (fail_addr !== 4'd5) begin n_bad++; $display("[TB] FAIL sf_fail_addr: got %0d want 5", fail_addr); end
      n_cmp++; if (fail_exp !== 8'h55) begin n_bad++; $display("[TB] FAIL sf_fail_exp: got %h want 55", fail_exp); end
      n_cmp++; if (fail_act !== 8'h54) begin n_bad++; $display("[TB] FAIL sf_fail_act: got %h want 54", fail_act); end
      n_cmp++; if (err_cnt !== 8'(exp_err)) begin n_bad++; $display("[TB] FAIL sf_err_cnt: got %0d want %0d", err_cnt, exp_err); end
      n_cmp++; if (done_cyc !== exp_done) begin n_bad++; $display("[TB] FAIL sf_done_cyc: got %0d want %0d", done_cyc, exp_done); end
   endtask

   task automatic test_reset_midrun();
      fault_en = 1'b1;
      run_session(62, 1'b0, 60);
      n_cmp++; if (fail_h[60] !== 1'b1) begin n_bad++; $display("[TB] FAIL rm_fail_before_rst: got %b want 1", fail_h[60]); end
      n_cmp++; if (zero_h[61] !== 1'b1) begin n_bad++; $display("[TB] FAIL rm_outputs_zero: got %b want 1", zero_h[61]); end
      fault_en = 1'b0;
      run_session(185, 1'b0, -1);
      n_cmp++; if (busy_cnt !== 176) begin n_bad++; $display("[TB] FAIL rm_busy_cnt: got %0d want 176", busy_cnt); end
      n_cmp++; if (done_cyc !== 177) begin n_bad++; $display("[TB] FAIL rm_done_cyc: got %0d want 177", done_cyc); end
      n_cmp++; if ({fail, err_cnt} !== 9'd0) begin n_bad++; $display("[TB] FAIL rm_status_clear: got %h want 0", {fail, err_cnt}); end
   endtask

   task automatic test_start_held();
      fault_en = 1'b0;
      run_session(182, 1'b1, -1);
      n_cmp++; if (busy_cnt !== 176) begin n_bad++; $display("[TB] FAIL sh_busy_cnt: got %0d want 176", busy_cnt); end
      n_cmp++; if (done_cyc !== 177) begin n_bad++; $display("[TB] FAIL sh_done_cyc: got %0d want 177", done_cyc); end
      n_cmp++; if (busy_h[178] !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_idle_c178: got %b want 0", busy_h[178]); end
      n_cmp++; if (busy_h[179] !== 1'b1) begin n_bad++; $display("[TB] FAIL sh_rebusy_c179: got %b want 1", busy_h[179]); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'd0;
      test_reset();
      test_fault_free();
      test_stuck_fault();
      test_reset_midrun();
      test_start_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram16_8_bist.md
# ram16_8_bist

Built-in self-test initiator for the 16x8 synchronous RAM. On `start`, it drives the RAM's address, data, read and write pins through a March C- sequence and compares every read against the expected background. It reports pass/fail, the first failing location with expected and actual data, and an error count. It sits between the test/control logic and the RAM port, muxed ahead of the functional user.

## Interface
- `PATTERN`, default 8'h55: data background written as "0". Its bitwise complement is the "1" value.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `mem_dataout`  in  8  RAM read data; valid the cycle after a read cycle.
- `mem_addr`  out  4  RAM address.
- `mem_datain`  out  8  RAM write data.
- `mem_read`  out  1  RAM read strobe.
- `mem_write`  out  1  RAM write strobe.
- `busy`  out  1  test in progress.
- `done`  out  1  one-cycle pulse at test end.
- `fail`  out  1  sticky; at least one mismatch.
- `fail_addr`  out  4  address of the first mismatch.
- `fail_exp`  out  8  expected data at the first mismatch.
- `fail_act`  out  8  actual data at the first mismatch.
- `err_cnt`  out  8  mismatch count; saturates at 255.

## Operation
- States:
  - IDLE.
  - W0: element 0.
  - RD: read phase.
  - WRC: write plus compare.
  - R5: final read.
  - C5: final compare.
  - DONE.
- Elements: E0 ⇑(w0), E1 ⇑(r0,w1), E2 ⇑(r1,w0), E3 ⇓(r0,w1), E4 ⇓(r1,w0), E5 ⇑(r0).
  - ⇑ means address 0→15; ⇓ means 15→0.
- IDLE:
  - All RAM strobes are low and busy=0.
  - `start`=1 clears `fail`, `fail_*` and `err_cnt`, then enters W0 at address 0.
- W0: one cycle per address, with `mem_write`=1 and `mem_datain`=PATTERN. After address 15, go to RD with element E1.
- RD: `mem_read`=1 at the current address. Next state is WRC.
- WRC:
  - `mem_write`=1 with the element's write value.
  - In the same cycle, compare `mem_dataout` with the element's read value.
  - Then step the address in the element's direction and return to RD.
  - At the element's last address, advance the element instead. After E4, go to R5 at address 0.
- R5 then C5: read, then compare with PATTERN, repeated for each address. After address 15, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Mismatch handling:
  - Every mismatch increments `err_cnt`, saturating at 255.
  - The first mismatch since `start` sets `fail` and captures `fail_addr`, `fail_exp` and `fail_act`. Later mismatches do not overwrite the captured fields.
- `mem_read` and `mem_write` are never high in the same cycle.
- `start` is ignored while busy or in DONE.

## Timing
- Reset values:
  - All outputs are 0, including `mem_addr`=0 and `mem_datain`=0.
  - State is IDLE.
- Cycle numbering: `start` is sampled in cycle 0. The first W0 write is driven in cycle 1.
- Cycle budget:
  - E0 takes 16 cycles.
  - E1 to E4 take 32 cycles each.
  - E5 takes 32 cycles.
  - Total: 176 active cycles.
- `busy`=1 in cycles 1–176. `done`=1 in cycle 177. Back in IDLE in cycle 178.
- All outputs are registered.
- The compare in a WRC or C5 cycle uses `mem_dataout` as produced by the RAM from the read in the preceding cycle.
- `rst` in any state returns to IDLE on that edge, with all outputs at reset values. No `done` pulse is produced.
  - The RAM contents are then undefined from the BIST's point of view.

## Configuration
- `BIST_ABORT_ON_FAIL_EN`
  - Defined: the first mismatch moves the FSM to DONE on the next edge. No further RAM cycles are issued and `err_cnt` is 1.
  - Undefined (default): the full 176-cycle sequence always runs, and `err_cnt` reports the total number of mismatches.

## Test plan
- **Fault-free RAM model, PATTERN=8'h55, start pulse:**
  - `busy` is high for 176 cycles and `done` pulses in cycle 177.
  - `fail`=0 and `err_cnt`=0.
  - RAM final contents are 8'h55 everywhere.
- **Address/strobe trace:**
  - E3 issues reads to addresses 15,14,…,0.
  - No cycle has `mem_read` and `mem_write` both high.
  - Exactly 16+64+16=96 write-or-read cycles occur in E0, E1–E4 writes and E5 respectively, as counted on the strobes.
- **Bit 0 of address 5 stuck at 0, abort macro undefined:**
  - `fail`=1, `fail_addr`=5, `fail_exp`=8'h55, `fail_act`=8'h54.
  - `err_cnt`=3, from the r0 reads in E1, E3 and E5.
  - `done` still occurs in cycle 177.
- **Same fault with `BIST_ABORT_ON_FAIL_EN` defined:**
  - The mismatch occurs in E1's WRC for address 5, in cycle 28.
  - `done` pulses in cycle 29, with `err_cnt`=1 and the same capture fields.
- **`rst` asserted in cycle 60, then a new `start`:**
  - All outputs read 0 the cycle after reset.
  - The restarted run completes in 176 busy cycles with the prior `fail` state cleared.
- **`start` held high for the whole run:**
  - The second acceptance happens only from IDLE, i.e. `busy` rises again in cycle 179.
  - There is no re-trigger mid-run.
